// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: FSM states, round count, rotate amounts and
// round constants for both SHA-256 (32-bit words) and SHA-512 (64-bit words).
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } sha2_state_e;

    // Rotate/shift amounts in the order
    // Sigma0(a,b,c), Sigma1(a,b,c), sigma0(rotA,rotB,shr), sigma1(rotA,rotB,shr).
    localparam int unsigned ROT512 [12] = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};
    localparam int unsigned ROT256 [12] = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};

    // SHA-512 round constants. The SHA-256 constants are the upper 32 bits
    // of the first 64 entries, so one table serves both widths.
    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic int unsigned rounds_f(input int unsigned w);
        return (w == 64) ? 80 : 64;
    endfunction

    function automatic int unsigned rot_amt(input int unsigned w, input int unsigned idx);
        return (w == 64) ? ROT512[idx] : ROT256[idx];
    endfunction

    // Round constant for either width, right-aligned in 64 bits.
    function automatic logic [63:0] k_lookup(input int unsigned w, input int unsigned idx);
        return (w == 64) ? K512[idx] : {32'h0, K512[idx][63:32]};
    endfunction

endpackage

// File: rtl/sha2_round_comb.sv
// One SHA-2 compression round plus next message-schedule word, purely
// combinational; rotate amounts follow the word width.
module sha2_round_comb
    import sha2_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic [8*WORD_W-1:0] st_i,
    input  logic [WORD_W-1:0]   w_t_i,
    input  logic [WORD_W-1:0]   w_t1_i,
    input  logic [WORD_W-1:0]   w_t9_i,
    input  logic [WORD_W-1:0]   w_t14_i,
    input  logic [WORD_W-1:0]   k_i,
    output logic [8*WORD_W-1:0] st_o,
    output logic [WORD_W-1:0]   w_new_o
);

    localparam int unsigned BS0_A = rot_amt(WORD_W, 0);
    localparam int unsigned BS0_B = rot_amt(WORD_W, 1);
    localparam int unsigned BS0_C = rot_amt(WORD_W, 2);
    localparam int unsigned BS1_A = rot_amt(WORD_W, 3);
    localparam int unsigned BS1_B = rot_amt(WORD_W, 4);
    localparam int unsigned BS1_C = rot_amt(WORD_W, 5);
    localparam int unsigned SS0_A = rot_amt(WORD_W, 6);
    localparam int unsigned SS0_B = rot_amt(WORD_W, 7);
    localparam int unsigned SS0_C = rot_amt(WORD_W, 8);
    localparam int unsigned SS1_A = rot_amt(WORD_W, 9);
    localparam int unsigned SS1_B = rot_amt(WORD_W, 10);
    localparam int unsigned SS1_C = rot_amt(WORD_W, 11);

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
    logic [WORD_W-1:0] bsig0, bsig1, ch, maj, t1, t2, ssig0, ssig1;

    assign {a, b, c, d, e, f, g, h} = st_i;

    // Round function: T1/T2 and the register rotation a..h.
    always_comb begin
        bsig0 = rotr(a, BS0_A) ^ rotr(a, BS0_B) ^ rotr(a, BS0_C);
        bsig1 = rotr(e, BS1_A) ^ rotr(e, BS1_B) ^ rotr(e, BS1_C);
        ch    = (e & f) ^ (~e & g);
        maj   = (a & b) ^ (a & c) ^ (b & c);
        t1    = h + bsig1 + ch + k_i + w_t_i;
        t2    = bsig0 + maj;
        st_o  = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

    // Message expansion: W[t+16] from the current 16-word window.
    always_comb begin
        ssig0   = rotr(w_t1_i, SS0_A) ^ rotr(w_t1_i, SS0_B) ^ (w_t1_i >> SS0_C);
        ssig1   = rotr(w_t14_i, SS1_A) ^ rotr(w_t14_i, SS1_B) ^ (w_t14_i >> SS1_C);
        w_new_o = ssig1 + w_t9_i + ssig0 + w_t_i;
    end

endmodule

// File: rtl/sha2_compress_engine.sv
// Iterative SHA-2 block compressor, one round per clock (SHA-256 or SHA-512
// selected by WORD_W). Round constants come from an external ROM via k_idx/k_in.
// Optional macro SHA2_FEEDFWD_EN: h_out is the chaining sum H + {a..h};
// otherwise h_out is the raw working variables and no H copy is kept.
module sha2_compress_engine
    import sha2_pkg::*;
#(
    parameter int WORD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [16*WORD_W-1:0] blk_in,
    input  logic [8*WORD_W-1:0]  h_in,
    output logic [6:0]           k_idx,
    input  logic [WORD_W-1:0]    k_in,
    output logic                 busy,
    output logic                 done,
    output logic [8*WORD_W-1:0]  h_out
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_compress_engine: WORD_W must be 32 or 64");
    end

    localparam int unsigned ROUNDS = rounds_f(WORD_W);
    localparam logic [6:0]  LAST_T = 7'(ROUNDS - 1);

    sha2_state_e            state_q, state_d;
    logic [6:0]             t_q, t_d;
    logic [8*WORD_W-1:0]    work_q, work_d;
    logic [16*WORD_W-1:0]   win_q, win_d;
    logic [8*WORD_W-1:0]    hout_q, hout_d;
    logic                   done_q, done_d;
    logic [8*WORD_W-1:0]    round_st, result;
    logic [WORD_W-1:0]      w_new;

    // Window word j sits at bits [(16-j)*WORD_W-1 -: WORD_W]; word 0 is W[t].
    sha2_round_comb #(.WORD_W(WORD_W)) u_round (
        .st_i    (work_q),
        .w_t_i   (win_q[16*WORD_W-1 -: WORD_W]),
        .w_t1_i  (win_q[15*WORD_W-1 -: WORD_W]),
        .w_t9_i  (win_q[7*WORD_W-1 -: WORD_W]),
        .w_t14_i (win_q[2*WORD_W-1 -: WORD_W]),
        .k_i     (k_in),
        .st_o    (round_st),
        .w_new_o (w_new)
    );

`ifdef SHA2_FEEDFWD_EN
    logic [8*WORD_W-1:0] hsave_q;

    // Keep the incoming chaining value for the final feed-forward add.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsave_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            hsave_q <= h_in;
        end
    end

    // Wordwise feed-forward sum H + {a..h}.
    always_comb begin
        result = '0;
        for (int i = 0; i < 8; i++) begin
            result[i*WORD_W +: WORD_W] = hsave_q[i*WORD_W +: WORD_W] + work_q[i*WORD_W +: WORD_W];
        end
    end
`else
    assign result = work_q;
`endif

    // Next-state logic for the FSM, round counter, working state and window.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        work_d  = work_q;
        win_d   = win_q;
        hout_d  = hout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = h_in;
                    win_d   = blk_in;
                    t_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = round_st;
                win_d  = {win_q[15*WORD_W-1:0], w_new};
                if (t_q == LAST_T) begin
                    state_d = ST_FIN;
                end else begin
                    t_d = t_q + 7'd1;
                end
            end
            ST_FIN: begin
                hout_d  = result;
                done_d  = 1'b1;
                t_d     = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any block in flight and clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            work_q  <= '0;
            win_q   <= '0;
            hout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            work_q  <= work_d;
            win_q   <= win_d;
            hout_q  <= hout_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign h_out = hout_q;
    assign k_idx = (state_q == ST_RUN) ? t_q : 7'd0;

endmodule

// File: tb/tb_sha2_compress_engine.sv
// Self-checking bench for sha2_compress_engine: one SHA-512 and one SHA-256
// instance, an external K ROM, and a straightforward FIPS 180-4 reference model.
module tb_sha2_compress_engine;
    import sha2_pkg::*;

    localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
                                      64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                                      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                      64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};
    localparam logic [511:0]  ABC256 = {32'h61626380, 448'h0, 32'h18};
`ifdef SHA2_FEEDFWD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start64, busy64, done64;
    logic [1023:0] blk64;
    logic [511:0]  h64, hout64;
    logic [6:0]    kidx64;
    logic [63:0]   k64;
    logic          start32, busy32, done32;
    logic [511:0]  blk32;
    logic [255:0]  h32, hout32;
    logic [6:0]    kidx32;
    logic [31:0]   k32;

    int total = 0;
    int bad   = 0;

    assign k64 = K512[kidx64];
    assign k32 = K512[kidx32][63:32];

    sha2_compress_engine #(.WORD_W(64)) u64 (
        .clk(clk), .rst(rst), .start(start64), .blk_in(blk64), .h_in(h64),
        .k_idx(kidx64), .k_in(k64), .busy(busy64), .done(done64), .h_out(hout64));

    sha2_compress_engine #(.WORD_W(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .blk_in(blk32), .h_in(h32),
        .k_idx(kidx32), .k_in(k32), .busy(busy32), .done(done32), .h_out(hout32));

    // ---------------- reference model ----------------
    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Raw working variables a..h after all 80 rounds.
    function automatic logic [511:0] model64(input logic [511:0] hin, input logic [1023:0] blk);
        logic [63:0] w [80];
        logic [63:0] v [8];
        logic [63:0] t1, t2, s0, s1;
        logic [511:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[1023-64*i -: 64];
        for (int i = 16; i < 80; i++) begin
            s0 = ror64(w[i-15], 1) ^ ror64(w[i-15], 8) ^ (w[i-15] >> 7);
            s1 = ror64(w[i-2], 19) ^ ror64(w[i-2], 61) ^ (w[i-2] >> 6);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[511-64*i -: 64];
        for (int i = 0; i < 80; i++) begin
            t1 = v[7] + (ror64(v[4], 14) ^ ror64(v[4], 18) ^ ror64(v[4], 41))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K512[i] + w[i];
            t2 = (ror64(v[0], 28) ^ ror64(v[0], 34) ^ ror64(v[0], 39))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[511-64*i -: 64] = v[i];
        return r;
    endfunction

    function automatic logic [255:0] model32(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1, kk;
        logic [63:0] kfull;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror32(w[i-15], 7) ^ ror32(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror32(w[i-2], 17) ^ ror32(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            kfull = K512[i];
            kk = kfull[63:32];
            t1 = v[7] + (ror32(v[4], 6) ^ ror32(v[4], 11) ^ ror32(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk + w[i];
            t2 = (ror32(v[0], 2) ^ ror32(v[0], 13) ^ ror32(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i];
        return r;
    endfunction

    function automatic logic [511:0] addw64(input logic [511:0] x, input logic [511:0] y);
        logic [511:0] r;
        for (int i = 0; i < 8; i++) r[64*i +: 64] = x[64*i +: 64] + y[64*i +: 64];
        return r;
    endfunction
    function automatic logic [255:0] addw32(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    // Expected h_out from the model's raw working variables, and the digest
    // recovered from an observed h_out, for the compiled configuration.
    function automatic logic [511:0] exp64(input logic [511:0] hin, input logic [511:0] raw);
        return FF ? addw64(hin, raw) : raw;
    endfunction
    function automatic logic [255:0] exp32(input logic [255:0] hin, input logic [255:0] raw);
        return FF ? addw32(hin, raw) : raw;
    endfunction
    function automatic logic [511:0] dig64(input logic [511:0] hin, input logic [511:0] out);
        return FF ? out : addw64(hin, out);
    endfunction
    function automatic logic [255:0] dig32(input logic [255:0] hin, input logic [255:0] out);
        return FF ? out : addw32(hin, out);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one 64-bit block; lat is the edge count to done (-1 on timeout).
    task automatic run64(input logic [511:0] hin, input logic [1023:0] blk,
                         output logic [511:0] out, output int lat);
        h64 = hin; blk64 = blk; start64 = 1'b1;
        step();
        start64 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (done64) begin
                lat = c;
                break;
            end
        end
        out = hout64;
    endtask

    task automatic run32(input logic [255:0] hin, input logic [511:0] blk,
                         output logic [255:0] out, output int lat);
        h32 = hin; blk32 = blk; start32 = 1'b1;
        step();
        start32 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (done32) begin
                lat = c;
                break;
            end
        end
        out = hout32;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start64 = 1'b1; start32 = 1'b1;
        step();
        step();
        total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL reset_busy64 got=%b want=0", busy64); end
        total++; if (done64 !== 1'b0) begin bad++; $display("FAIL reset_done64 got=%b want=0", done64); end
        total++; if (hout64 !== 512'h0) begin bad++; $display("FAIL reset_hout64 got=%h want=0", hout64); end
        total++; if (kidx64 !== 7'd0) begin bad++; $display("FAIL reset_kidx64 got=%0d want=0", kidx64); end
        total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_busy32 got=%b want=0", busy32); end
        total++; if (hout32 !== 256'h0) begin bad++; $display("FAIL reset_hout32 got=%h want=0", hout32); end
        rst = 1'b0; start64 = 1'b0; start32 = 1'b0;
        step();
        total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL reset_start_ignored got=%b want=0", busy64); end
    endtask

    task automatic test_abc512();
        logic [511:0] out, d;
        int lat;
        run64(IV512, ABC512, out, lat);
        d = dig64(IV512, out);
        total++; if (lat !== 81) begin bad++; $display("FAIL abc512_latency got=%0d want=81", lat); end
        total++; if (out !== exp64(IV512, model64(IV512, ABC512)))
            begin bad++; $display("FAIL abc512_hout got=%h want=%h", out, exp64(IV512, model64(IV512, ABC512))); end
        total++; if (d[511:448] !== 64'hddaf35a193617aba)
            begin bad++; $display("FAIL abc512_digest_a got=%h want=ddaf35a193617aba", d[511:448]); end
        step();
        total++; if (done64 !== 1'b0) begin bad++; $display("FAIL abc512_done_width got=%b want=0", done64); end
        total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL abc512_idle_busy got=%b want=0", busy64); end
        total++; if (hout64 !== out) begin bad++; $display("FAIL abc512_hold got=%h want=%h", hout64, out); end
    endtask

    task automatic test_abc256();
        logic [255:0] out, d;
        int lat;
        run32(IV256, ABC256, out, lat);
        d = dig32(IV256, out);
        total++; if (lat !== 65) begin bad++; $display("FAIL abc256_latency got=%0d want=65", lat); end
        total++; if (out !== exp32(IV256, model32(IV256, ABC256)))
            begin bad++; $display("FAIL abc256_hout got=%h want=%h", out, exp32(IV256, model32(IV256, ABC256))); end
        total++; if (d[255:224] !== 32'hba7816bf)
            begin bad++; $display("FAIL abc256_digest_a got=%h want=ba7816bf", d[255:224]); end
        total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL abc256_busy_at_done got=%b want=0", busy32); end
    endtask

    task automatic test_random();
        logic [1023:0] b64;
        logic [511:0]  hh64, o64;
        logic [511:0]  b32;
        logic [255:0]  hh32, o32;
        int lat;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 32; i++) b64[32*i +: 32] = $urandom;
            for (int i = 0; i < 16; i++) hh64[32*i +: 32] = $urandom;
            run64(hh64, b64, o64, lat);
            total++; if (o64 !== exp64(hh64, model64(hh64, b64)))
                begin bad++; $display("FAIL rand64_%0d got=%h want=%h", n, o64, exp64(hh64, model64(hh64, b64))); end
            for (int i = 0; i < 16; i++) b32[32*i +: 32] = $urandom;
            for (int i = 0; i < 8; i++) hh32[32*i +: 32] = $urandom;
            run32(hh32, b32, o32, lat);
            total++; if (o32 !== exp32(hh32, model32(hh32, b32)))
                begin bad++; $display("FAIL rand32_%0d got=%h want=%h", n, o32, exp32(hh32, model32(hh32, b32))); end
        end
    endtask

    // Extra start pulses (with different inputs) during the run must be ignored.
    task automatic test_ignore_start();
        logic [511:0] out, want;
        int ndone, first;
        want = exp64(IV512, model64(IV512, ABC512));
        out = '0; ndone = 0; first = -1;
        h64 = IV512; blk64 = ABC512; start64 = 1'b1;
        step();
        for (int c = 1; c <= 200; c++) begin
            if (c == 10 || c == 40) begin
                start64 = 1'b1;
                h64 = {16{$urandom}};
                blk64 = {32{$urandom}};
            end else begin
                start64 = 1'b0;
            end
            step();
            if (c == 10) begin
                total++; if (kidx64 !== 7'd10) begin bad++; $display("FAIL ign_kidx got=%0d want=10", kidx64); end
                total++; if (busy64 !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b want=1", busy64); end
            end
            if (done64) begin
                ndone++;
                if (first < 0) begin first = c; out = hout64; end
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", ndone); end
        total++; if (first !== 81) begin bad++; $display("FAIL ign_latency got=%0d want=81", first); end
        total++; if (out !== want) begin bad++; $display("FAIL ign_hout got=%h want=%h", out, want); end
        total++; if (hout64 !== want) begin bad++; $display("FAIL ign_hold got=%h want=%h", hout64, want); end
    endtask

    // Reset mid-run (with start asserted alongside) aborts the block.
    task automatic test_reset_midrun();
        logic [511:0] out, d;
        int lat, ndone;
        h64 = IV512; blk64 = ABC512; start64 = 1'b1;
        step();
        start64 = 1'b0;
        for (int c = 1; c <= 30; c++) step();
        rst = 1'b1; start64 = 1'b1;
        step();
        rst = 1'b0; start64 = 1'b0;
        total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy64); end
        total++; if (hout64 !== 512'h0) begin bad++; $display("FAIL mid_hout got=%h want=0", hout64); end
        total++; if (kidx64 !== 7'd0) begin bad++; $display("FAIL mid_kidx got=%0d want=0", kidx64); end
        ndone = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (done64) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", ndone); end
        run64(IV512, ABC512, out, lat);
        d = dig64(IV512, out);
        total++; if (lat !== 81) begin bad++; $display("FAIL mid_restart_latency got=%0d want=81", lat); end
        total++; if (d[511:448] !== 64'hddaf35a193617aba)
            begin bad++; $display("FAIL mid_restart_digest got=%h want=ddaf35a193617aba", d[511:448]); end
    endtask

    // Two-block SHA-512 message with start held high. The second block is
    // accepted at the edge ending the done cycle, so pulses are ROUNDS+2 apart.
    task automatic test_back_to_back();
        logic [1023:0] b1, b2;
        logic [511:0]  chain1, out1, out2, want1, want2, d;
        logic [63:0]   w;
        int ndone, c1, c2;
        for (int i = 0; i < 14; i++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[55:0], 8'(8'h61 + i + j)};
            b1[1023-64*i -: 64] = w;
        end
        b1[127:64] = 64'h8000000000000000;
        b1[63:0]   = 64'h0;
        b2 = {960'h0, 64'h380};
        chain1 = addw64(IV512, model64(IV512, b1));
        want1  = exp64(IV512, model64(IV512, b1));
        want2  = exp64(chain1, model64(chain1, b2));
        out1 = '0; out2 = '0; ndone = 0; c1 = -1; c2 = -1;
        h64 = IV512; blk64 = b1; start64 = 1'b1;
        step();
        h64 = chain1; blk64 = b2;
        for (int c = 1; c <= 400; c++) begin
            step();
            if (ndone == 1 && c == c1 + 1) start64 = 1'b0;
            if (done64) begin
                ndone++;
                if (ndone == 1) begin c1 = c; out1 = hout64; end
                else begin c2 = c; out2 = hout64; break; end
            end
        end
        start64 = 1'b0;
        d = dig64(chain1, out2);
        total++; if (c1 !== 81) begin bad++; $display("FAIL b2b_first_latency got=%0d want=81", c1); end
        total++; if (c2 - c1 !== 82) begin bad++; $display("FAIL b2b_spacing got=%0d want=82", c2 - c1); end
        total++; if (out1 !== want1) begin bad++; $display("FAIL b2b_block1 got=%h want=%h", out1, want1); end
        total++; if (out2 !== want2) begin bad++; $display("FAIL b2b_block2 got=%h want=%h", out2, want2); end
        total++; if (d[511:448] !== 64'h8e959b75dae313da)
            begin bad++; $display("FAIL b2b_digest_a got=%h want=8e959b75dae313da", d[511:448]); end
        step();
        step();
        total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL b2b_idle_after got=%b want=0", busy64); end
    endtask

    initial begin
        rst = 1'b1;
        start64 = 1'b0; blk64 = '0; h64 = '0;
        start32 = 1'b0; blk32 = '0; h32 = '0;
        test_reset();
        test_abc512();
        test_abc256();
        test_random();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
